// File: rtl/note_envelope_if.sv
// note_envelope_if: note control, sample stream and status for the envelope.
// master drives notes/samples; slave is the envelope itself.
interface note_envelope_if #(
  parameter int SAMPLE_W  = 16,
  parameter int GAIN_BITS = 3,
  parameter int DUR_W     = 6
);
  logic                       note_start;
  logic [DUR_W-1:0]           note_duration;
  logic                       mode;
  logic                       note_off;
  logic                       beat;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_out_valid;
  logic [GAIN_BITS:0]         gain;
  logic                       busy;
  logic                       note_done;

  modport master (
    output note_start, note_duration, mode,
    output note_off, beat, sample_in, sample_valid,
    input  sample_out, sample_out_valid,
    input  gain, busy, note_done
  );

  modport slave (
    input  note_start, note_duration, mode,
    input  note_off, beat, sample_in, sample_valid,
    output sample_out, sample_out_valid,
    output gain, busy, note_done
  );
endinterface

// File: rtl/note_envelope.sv
// note_envelope: beat-paced decaying gain applied to a signed sample stream.
// Optional attack ramp enabled by defining NOTE_ENVELOPE_ATTACK_EN.
module note_envelope #(
  parameter int SAMPLE_W  = 16,
  parameter int GAIN_BITS = 3,
  parameter int DUR_W     = 6
) (
  input logic           clk,
  input logic           reset_n,
  note_envelope_if.slave bus
);

  localparam int FULL = 1 << GAIN_BITS;
  localparam int GW   = GAIN_BITS + 1;
  localparam int CW   = DUR_W + FULL;
  localparam int PW   = SAMPLE_W + GW + 1;

  localparam logic [GW-1:0] G_FULL = GW'(FULL);
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECAY   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
`ifdef NOTE_ENVELOPE_ATTACK_EN
  localparam logic [1:0] S_ATTACK  = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gain_q, gain_d;
  logic [GW-1:0]    step_q, step_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic                       out_vld_q, out_vld_d;

  logic [CW-1:0] d_eff;
  logic [CW-1:0] interval;
  logic [CW-1:0] cnt_inc;
  logic          can_off;

  logic signed [GW:0]           gain_s;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         prod_adj;
  logic signed [SAMPLE_W-1:0]   scaled;

  // Step interval: latched duration (0 read as 1), doubled per step
  // in exponential mode.
  always_comb begin
    d_eff    = (dur_q == '0) ? CW'(1) : CW'(dur_q);
    interval = mode_q ? d_eff : (d_eff << step_q);
    cnt_inc  = cnt_q + CW'(1);
`ifdef NOTE_ENVELOPE_ATTACK_EN
    can_off  = (state_q == S_DECAY) || (state_q == S_ATTACK);
`else
    can_off  = (state_q == S_DECAY);
`endif
  end

  // Envelope FSM: start beats note_off beats beat.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (bus.note_start) begin
      dur_d  = bus.note_duration;
      mode_d = bus.mode;
      step_d = '0;
      cnt_d  = '0;
`ifdef NOTE_ENVELOPE_ATTACK_EN
      gain_d  = '0;
      state_d = S_ATTACK;
`else
      gain_d  = G_FULL;
      state_d = S_DECAY;
`endif
    end else if (bus.note_off && can_off) begin
      state_d = S_RELEASE;
      cnt_d   = '0;
    end else if (bus.beat) begin
      case (state_q)
        S_DECAY: begin
          if (cnt_inc < interval) begin
            cnt_d = cnt_inc;
          end else begin
            gain_d = gain_q - G_ONE;
            step_d = step_q + G_ONE;
            cnt_d  = '0;
            if (gain_q == G_ONE) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              step_d  = '0;
            end
          end
        end
        S_RELEASE: begin
          if (gain_q <= G_ONE) begin
            gain_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
            step_d  = '0;
          end else begin
            gain_d = gain_q - G_ONE;
          end
        end
`ifdef NOTE_ENVELOPE_ATTACK_EN
        S_ATTACK: begin
          gain_d = gain_q + G_ONE;
          if (gain_q == G_FULL - G_ONE) begin
            step_d  = '0;
            cnt_d   = '0;
            state_d = S_DECAY;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Scale by gain/FULL, truncating toward zero; uses pre-edge gain.
  always_comb begin
    gain_s    = $signed({1'b0, gain_q});
    prod      = bus.sample_in * gain_s;
    prod_adj  = prod;
    if (prod[PW-1]) begin
      prod_adj = prod + $signed(PW'(FULL - 1));
    end
    scaled    = SAMPLE_W'(prod_adj >>> GAIN_BITS);
    out_d     = bus.sample_valid ? scaled : out_q;
    out_vld_d = bus.sample_valid;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gain_q    <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      dur_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.sample_out       = out_q;
  assign bus.sample_out_valid = out_vld_q;
  assign bus.gain             = gain_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.note_done        = done_q;

endmodule

// File: doc/note_envelope.md
# note_envelope

Parametrised per-note amplitude envelope for the synthesis chain, sitting between the sample generator and the output mixer. It scales each incoming signed sample by a gain that decays in 1/2^GAIN_BITS steps, paced by the tempo `beat` tick. Step spacing is either exponential (each interval double the previous) or linear. A note-off forces a fast release.

## Interface
- `SAMPLE_W`, 16: signed sample width.
- `GAIN_BITS`, 3: gain resolution; full scale FULL = 2^GAIN_BITS.
- `DUR_W`, 6: width of `note_duration`.
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `note_start` in 1: one-cycle pulse; begins a new note and latches `note_duration` and `mode`.
- `note_duration` in DUR_W: base step interval, in beats; 0 is treated as 1.
- `mode` in 1: 0 = exponential spacing, 1 = linear spacing.
- `note_off` in 1: one-cycle pulse; enters release.
- `beat` in 1: one-cycle tempo tick.
- `sample_in` in SAMPLE_W: signed input sample.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `sample_out` out SAMPLE_W: signed scaled sample.
- `sample_out_valid` out 1: `sample_out` updated this cycle.
- `gain` out GAIN_BITS+1: current gain, 0..FULL.
- `busy` out 1: state is not IDLE.
- `note_done` out 1: one-cycle pulse when gain reaches 0.

## Operation
- States: IDLE, ATTACK (only with the macro), DECAY, RELEASE.
- IDLE: gain = 0.
  - `note_start`: step = 0, cnt = 0, gain = FULL, go to DECAY.
  - With the macro, `note_start` instead sets gain = 0 and goes to ATTACK.
- DECAY, on each `beat`:
  - If cnt+1 < interval(step), then cnt++.
  - Otherwise gain--, step++, cnt = 0.
  - If the new gain is 0: pulse `note_done`, go to IDLE.
- Interval:
  - Linear mode: interval = D.
  - Exponential mode: interval = D << step, held in a counter of DUR_W + 2^GAIN_BITS bits, no saturation needed.
  - D is the latched duration, with 0 mapped to 1.
- `note_off` in DECAY or ATTACK: go to RELEASE, cnt cleared.
- RELEASE: gain-- on every `beat`. At 0: pulse `note_done`, go to IDLE. `note_off` in IDLE or RELEASE is ignored.
- Priority within one cycle: `note_start` > `note_off` > `beat`. `note_start` in any state restarts the note.
- Scaling:
  - p = sample_in × gain, computed signed and full width.
  - sample_out = p / FULL, truncated toward zero. For negative p, add FULL−1 before the arithmetic shift.
  - The result always fits SAMPLE_W because gain ≤ FULL.

## Timing
- Reset values: `sample_out` = 0, `sample_out_valid` = 0, `gain` = 0, `busy` = 0, `note_done` = 0, state IDLE, all counters 0.
- Sample path:
  - Latency is 1 cycle: `sample_out_valid` is `sample_valid` delayed by one register.
  - The product uses the `gain` visible in the same cycle as `sample_valid`, before any update on that edge.
  - `sample_out` holds its value when not valid.
- Gain path:
  - `gain` changes on the edge that samples the qualifying `beat`.
  - `note_start` sets `gain` = FULL on the next edge (0 with the macro).
- `note_done` asserts on the same edge that `gain` becomes 0. `busy` drops on that edge.
- A `reset_n` assertion mid-note returns all state and outputs to their reset values immediately. No `note_done` pulse is issued.

## Configuration
- `NOTE_ENVELOPE_ATTACK_EN` defined:
  - ATTACK state is present.
  - From gain 0, gain++ on each `beat`.
  - Reaching FULL clears step and cnt and goes to DECAY.
  - `note_off` during ATTACK goes to RELEASE.
- Not defined: no ATTACK state. `note_start` loads FULL directly into DECAY.

## Test plan
- Exponential decay: D=3, mode 0, `sample_in`=10400 streaming. `sample_out` must read 9100 after 3 beats, 7800 after a further 6, 6500 after a further 12, 0 after 765 beats total. `note_done` pulses exactly once.
- Linear, signed: D=2, mode 1, `sample_in`=−10400. Output must step −9100, −7800 … 0, one step every 2 beats (16 beats total). `busy` deasserts with `note_done`.
- Rounding: gain 7, `sample_in`=±1001 gives ±875. `sample_in`=−32768 at gain FULL gives −32768. `note_duration`=0 behaves exactly as D=1.
- Release: `note_off` after gain=5. Gain must drop 4, 3, 2, 1, 0 on the next five beats. `note_off` in IDLE changes nothing.
- Priority and reset:
  - `note_start`, `note_off` and `beat` in one cycle: gain=FULL, state DECAY, cnt=0.
  - `reset_n` low mid-DECAY: all outputs 0 asynchronously, with no `note_done`.
- With `NOTE_ENVELOPE_ATTACK_EN`: `note_start` gives gain 0, 1, … 8 over 8 beats, then the D=3 decay as in the first scenario. `note_off` at gain 4 ramps down to 0 in 4 beats.
